// File: rtl/core_seq_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the rv64i core.
// Drives the imem/dmem handshakes and the IR/RF/PC strobes; halts or traps on ebreak, ecall, illegal or bus timeout.
module core_seq_fsm #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            ir_we,
  input  logic [4:0]      enables,
  input  logic [2:0]      specinst,
  input  logic            decode_error,
  input  logic [1:0]      env_exception,
  input  logic            br_taken,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            halted,
  output logic [2:0]      trap_cause,
  output logic [XLEN-1:0] instret,
  output logic [2:0]      state
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [2:0] SP_BR    = 3'd0;
  localparam logic [2:0] SP_JAL   = 3'd1;
  localparam logic [2:0] SP_JALR  = 3'd2;
  localparam logic [2:0] SP_STORE = 3'd5;

  localparam logic [2:0] C_ILLEGAL = 3'd1;
  localparam logic [2:0] C_ECALL   = 3'd2;
  localparam logic [2:0] C_IFETCH  = 3'd3;
  localparam logic [2:0] C_DMEM    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [2:0]      cause_q, cause_d;
  logic            run_q;
  logic [4:0]      en_q;
  logic [2:0]      spec_q;
  logic [XLEN-1:0] instret_q;

  // State, timeout, latched decode fields and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      cause_q   <= '0;
      run_q     <= 1'b0;
      en_q      <= '0;
      spec_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cause_q <= cause_d;
      run_q   <= 1'b1;
      if (state_q == S_DECODE) begin
        en_q   <= enables;
        spec_q <= specinst;
      end
      if (state_q == S_WB) instret_q <= instret_q + XLEN'(1);
    end
  end

  // Next-state and Moore output decode; strobes also qualify on ack/br_taken.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    cause_d  = cause_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (run_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (tmo_q == TMO_LIMIT) begin
            state_d = S_TRAP;
            cause_d = C_IFETCH;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_DECODE: begin
        if (decode_error) begin
          state_d = S_TRAP;
          cause_d = C_ILLEGAL;
        end else if (env_exception[1]) begin
          state_d = S_HALT;
        end else if (env_exception[0]) begin
          state_d = S_TRAP;
          cause_d = C_ECALL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (en_q[3] || en_q[4]) begin
          state_d = S_MEM;
          tmo_d   = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = en_q[4];
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (tmo_q == TMO_LIMIT) begin
          state_d = S_TRAP;
          cause_d = C_DMEM;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        rf_we   = en_q[2] && (spec_q != SP_STORE) && (spec_q != SP_BR);
        if (((spec_q == SP_BR) && br_taken) || (spec_q == SP_JAL)) pc_sel = 2'd1;
        else if (spec_q == SP_JALR)                                pc_sel = 2'd2;
        state_d = S_FETCH;
        tmo_d   = '0;
      end
      S_HALT, S_TRAP: halted = 1'b1;
      default: begin
        state_d = S_TRAP;
        cause_d = C_ILLEGAL;
      end
    endcase
  end

  assign state      = state_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_core_seq_fsm.sv
// Scoreboard bench for core_seq_fsm: per-instruction expectations are queued at issue and checked at retire/stop.
module tb_core_seq_fsm;

  localparam int MEM_TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0, ir_we;
  logic [4:0]  enables = '0;
  logic [2:0]  specinst = 3'd7;
  logic        decode_error = 1'b0;
  logic [1:0]  env_exception = '0;
  logic        br_taken = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic        rf_we, pc_we;
  logic [1:0]  pc_sel;
  logic        halted;
  logic [2:0]  trap_cause;
  logic [63:0] instret;
  logic [2:0]  state;

  core_seq_fsm #(.XLEN(64), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .enables(enables), .specinst(specinst), .decode_error(decode_error),
    .env_exception(env_exception), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .trap_cause(trap_cause), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cycles;
    int         ireq;
    int         dreq;
    int         nrf;
    logic       dwe;
    logic [1:0] sel;
    logic       retire;
    logic       halted;
    logic [2:0] cause;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] instret_m = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    check("rst.imem_req", 64'(imem_req), 64'd0);
    check("rst.state", 64'(state), 64'd0);
    check("rst.instret", instret, 64'd0);
    check("rst.halted", 64'(halted), 64'd0);
    check("rst.cause", 64'(trap_cause), 64'd0);
    check("rst.strobes", 64'({ir_we, rf_we, pc_we, dmem_req, dmem_we, pc_sel}), 64'd0);
    instret_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.req_release", 64'(imem_req), 64'd0);
  endtask

  // Issue one instruction: build expectation, respond as imem/dmem, then pop and compare.
  task automatic run_inst(input string name, input logic [4:0] en, input logic [2:0] sp,
                          input logic derr, input logic [1:0] env, input logic brt,
                          input int idly, input int ddly);
    exp_t       e, o;
    logic       mem, ito, dto, done, dwe;
    int         ni, nd, nrf, cyc;
    logic [1:0] sel;

    ito = (idly > MEM_TO);
    mem = en[3] | en[4];
    dto = mem && (ddly > MEM_TO);
    e = '{cycles: 0, ireq: 0, dreq: 0, nrf: 0, dwe: 1'b0, sel: 2'd0, retire: 1'b0, halted: 1'b0, cause: 3'd0};
    e.ireq = ito ? MEM_TO + 1 : idly + 1;
    if (ito) begin
      e.halted = 1'b1; e.cause = 3'd3; e.cycles = e.ireq + 1;
    end else if (derr || env != 2'd0) begin
      e.halted = 1'b1;
      e.cause  = derr ? 3'd1 : (env[1] ? 3'd0 : 3'd2);
      e.cycles = e.ireq + 2;
    end else begin
      if (mem) begin
        e.dreq = dto ? MEM_TO + 1 : ddly + 1;
        e.dwe  = en[4];
      end
      e.cycles = e.ireq + e.dreq + 3;
      if (dto) begin
        e.halted = 1'b1; e.cause = 3'd4;
      end else begin
        e.retire = 1'b1;
        e.nrf    = (en[2] && sp != 3'd5 && sp != 3'd0) ? 1 : 0;
        e.sel    = (sp == 3'd1 || (sp == 3'd0 && brt)) ? 2'd1 : (sp == 3'd2 ? 2'd2 : 2'd0);
      end
    end
    if (e.retire) instret_m = instret_m + 64'd1;
    sb_q.push_back(e);

    enables = en; specinst = sp; decode_error = derr; env_exception = env; br_taken = brt;
    ni = 0; nd = 0; nrf = 0; cyc = 0; done = 1'b0; dwe = 1'b0; sel = 2'd0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      imem_ack = imem_req && (ni == idly);
      dmem_ack = dmem_req && (nd == ddly);
      #1;
      cyc++;
      if (imem_req) ni++;
      if (dmem_req) begin
        nd++;
        if (dmem_we) dwe = 1'b1;
      end
      if (rf_we) nrf++;
      if (pc_we) begin
        done = 1'b1;
        sel  = pc_sel;
      end
      if (halted) done = 1'b1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    check({name, ".done"}, 64'(done), 64'd1);

    o = sb_q.pop_front();
    check({name, ".cycles"}, 64'(cyc), 64'(o.cycles));
    check({name, ".imem_req_cyc"}, 64'(ni), 64'(o.ireq));
    check({name, ".dmem_req_cyc"}, 64'(nd), 64'(o.dreq));
    check({name, ".dmem_we"}, 64'(dwe), 64'(o.dwe));
    check({name, ".rf_we"}, 64'(nrf), 64'(o.nrf));
    check({name, ".halted"}, 64'(halted), 64'(o.halted));
    if (o.retire) begin
      check({name, ".pc_sel"}, 64'(sel), 64'(o.sel));
      @(posedge clk);
      #1;
      check({name, ".instret"}, instret, instret_m);
    end else begin
      check({name, ".cause"}, 64'(trap_cause), 64'(o.cause));
      check({name, ".state"}, 64'(state), (o.cause == 3'd0) ? 64'd5 : 64'd6);
      check({name, ".req_off"}, 64'({imem_req, dmem_req}), 64'd0);
      check({name, ".instret"}, instret, instret_m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard;
    do_reset();

    // ADDI stream, mem ops, control flow
    repeat (3) run_inst("addi", 5'b00101, 3'd7, 1'b0, 2'd0, 1'b0, 0, 0);
    check("addi3.instret", instret, 64'd3);
    run_inst("ld_d3",   5'b01101, 3'd6, 1'b0, 2'd0, 1'b0, 0, 3);
    run_inst("sd",      5'b10111, 3'd5, 1'b0, 2'd0, 1'b0, 0, 0);
    run_inst("beq_t",   5'b00011, 3'd0, 1'b0, 2'd0, 1'b1, 0, 0);
    run_inst("beq_nt",  5'b00011, 3'd0, 1'b0, 2'd0, 1'b0, 0, 0);
    run_inst("jal",     5'b00100, 3'd1, 1'b0, 2'd0, 1'b0, 0, 0);
    run_inst("jalr",    5'b00101, 3'd2, 1'b0, 2'd0, 1'b1, 0, 0);
    run_inst("lui",     5'b00100, 3'd4, 1'b0, 2'd0, 1'b0, 1, 0);
    run_inst("if_lim",  5'b00101, 3'd7, 1'b0, 2'd0, 1'b0, MEM_TO, 0);
    run_inst("ld_lim",  5'b01101, 3'd6, 1'b0, 2'd0, 1'b0, 0, MEM_TO);

    // Reset asserted mid-MEM
    enables = 5'b01101; specinst = 3'd6; decode_error = 1'b0; env_exception = 2'd0;
    n = 0; guard = 0;
    while (n < 2 && guard < 20) begin
      @(negedge clk);
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      #1;
      guard++;
      if (dmem_req) n++;
    end
    imem_ack = 1'b0;
    check("midrst.reached_mem", 64'(n), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.dmem_req", 64'(dmem_req), 64'd0);
    check("midrst.instret", instret, 64'd0);
    check("midrst.state", 64'(state), 64'd0);
    instret_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst.req_release", 64'(imem_req), 64'd0);
    run_inst("post_rst", 5'b00101, 3'd7, 1'b0, 2'd0, 1'b0, 0, 0);

    // ebreak halts; late acks are ignored
    run_inst("ebreak", 5'b00000, 3'd7, 1'b0, 2'd2, 1'b0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'b1;
      #1;
      check("halt.late_ack_req", 64'({imem_req, dmem_req, ir_we, pc_we}), 64'd0);
      check("halt.late_ack_state", 64'(state), 64'd5);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    check("halt.instret_frozen", instret, instret_m);

    do_reset();
    run_inst("ecall", 5'b00000, 3'd7, 1'b0, 2'd1, 1'b0, 0, 0);
    do_reset();
    run_inst("ebrk_ecall", 5'b00000, 3'd7, 1'b0, 2'd3, 1'b0, 0, 0);
    do_reset();
    run_inst("illegal", 5'b00101, 3'd7, 1'b1, 2'd2, 1'b0, 0, 0);

    // Bus timeouts
    do_reset();
    run_inst("addi_pre", 5'b00101, 3'd7, 1'b0, 2'd0, 1'b0, 2, 0);
    run_inst("if_tmo", 5'b00101, 3'd7, 1'b0, 2'd0, 1'b0, 99, 0);
    do_reset();
    run_inst("dm_tmo", 5'b10011, 3'd5, 1'b0, 2'd0, 1'b0, 0, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
